// File: rtl/ro_puf_controller_if.sv
// Request/response and RO-array signal bundle for the RO PUF measurement controller.
// The controller uses the slave view; the requester / counter datapath side uses master.
interface ro_puf_controller_if #(
    parameter int NUM_PAIRS = 128,
    parameter int SEL_W     = 7,
    parameter int CNT_W     = 16
);
    logic                 req;
    logic                 busy;
    logic [SEL_W-1:0]     ro_sel;
    logic                 ro_clr;
    logic                 ro_en;
    logic [CNT_W-1:0]     cnt_a;
    logic [CNT_W-1:0]     cnt_b;
    logic [NUM_PAIRS-1:0] resp;
    logic                 resp_valid;
    logic                 resp_ack;
    logic [SEL_W:0]       ties;

    modport slave (
        input  req, cnt_a, cnt_b, resp_ack,
        output busy, ro_sel, ro_clr, ro_en, resp, resp_valid, ties
    );

    modport master (
        output req, cnt_a, cnt_b, resp_ack,
        input  busy, ro_sel, ro_clr, ro_en, resp, resp_valid, ties
    );
endinterface

// File: rtl/ro_puf_controller.sv
// RO PUF controller: per pair clear -> gated window -> settle -> compare, collecting one
// response bit per pair into a shadow word that is published with a valid/ack handshake.
module ro_puf_controller #(
    parameter int NUM_PAIRS = 128,
    parameter int SEL_W     = 7,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ro_puf_controller_if.slave   bus
);

    localparam int WMAX  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int WIN_W = (WMAX > 1) ? $clog2(WMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_MEASURE = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_LOAD    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t               state_q;
    logic [SEL_W-1:0]     idx_q;
    logic [WIN_W-1:0]     win_q;
    logic [NUM_PAIRS-1:0] shadow_q;
    logic [NUM_PAIRS-1:0] shadow_d;
    logic [SEL_W:0]       tie_q;
    logic [SEL_W:0]       tie_d;
    logic                 busy_q;
    logic [SEL_W-1:0]     ro_sel_q;
    logic                 ro_clr_q;
    logic                 ro_en_q;
    logic [NUM_PAIRS-1:0] resp_q;
    logic                 resp_valid_q;
    logic [SEL_W:0]       ties_q;
    logic                 last_pair;

    // Compare result for the current pair; raw unsigned counts, wrap is the datapath's business.
    always_comb begin
        shadow_d        = shadow_q;
        shadow_d[idx_q] = (bus.cnt_a > bus.cnt_b);
        tie_d           = tie_q;
        if ((bus.cnt_a == bus.cnt_b) && (tie_q != '1)) begin
            tie_d = tie_q + 1'b1;
        end
        last_pair = (idx_q == SEL_W'(NUM_PAIRS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            win_q        <= '0;
            shadow_q     <= '0;
            tie_q        <= '0;
            busy_q       <= 1'b0;
            ro_sel_q     <= '0;
            ro_clr_q     <= 1'b0;
            ro_en_q      <= 1'b0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            ties_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        state_q  <= S_CLEAR;
                        idx_q    <= '0;
                        shadow_q <= '0;
                        tie_q    <= '0;
                        busy_q   <= 1'b1;
                        ro_sel_q <= '0;
                        ro_clr_q <= 1'b1;
                        ro_en_q  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_q  <= S_MEASURE;
                    ro_clr_q <= 1'b0;
                    ro_en_q  <= 1'b1;
                    win_q    <= WIN_W'(WINDOW - 1);
                end
                S_MEASURE: begin
                    if (win_q == '0) begin
                        state_q <= S_SETTLE;
                        ro_en_q <= 1'b0;
                        win_q   <= WIN_W'(SETTLE - 1);
                    end else begin
                        win_q <= win_q - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (win_q == '0) begin
                        state_q <= S_COMPARE;
                    end else begin
                        win_q <= win_q - 1'b1;
                    end
                end
                S_COMPARE: begin
                    shadow_q <= shadow_d;
                    tie_q    <= tie_d;
                    if (last_pair) begin
                        state_q <= S_LOAD;
                    end else begin
                        state_q  <= S_CLEAR;
                        idx_q    <= idx_q + 1'b1;
                        ro_sel_q <= idx_q + 1'b1;
                        ro_clr_q <= 1'b1;
                    end
                end
                // Publish only once every bit is in; resp/ties never show a partial run.
                S_LOAD: begin
                    state_q      <= S_DONE;
                    resp_q       <= shadow_q;
                    ties_q       <= tie_q;
                    resp_valid_q <= 1'b1;
                end
                S_DONE: begin
                    if (resp_valid_q && bus.resp_ack) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    idx_q        <= '0;
                    win_q        <= '0;
                    shadow_q     <= '0;
                    tie_q        <= '0;
                    busy_q       <= 1'b0;
                    ro_sel_q     <= '0;
                    ro_clr_q     <= 1'b0;
                    ro_en_q      <= 1'b0;
                    resp_q       <= '0;
                    resp_valid_q <= 1'b0;
                    ties_q       <= '0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.ro_sel     = ro_sel_q;
    assign bus.ro_clr     = ro_clr_q;
    assign bus.ro_en      = ro_en_q;
    assign bus.resp       = resp_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.ties       = ties_q;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Bench for ro_puf_controller: table of count vectors, per-cycle waveform model, scoreboard on resp.
module tb_ro_puf_controller;

    localparam int NP  = 4;
    localparam int SW  = 2;
    localparam int WIN = 8;
    localparam int ST  = 2;
    localparam int CW  = 16;
    localparam int PT  = WIN + ST + 2;
    localparam int LAT = NP * PT + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ro_puf_controller_if #(.NUM_PAIRS(NP), .SEL_W(SW), .CNT_W(CW)) bus ();

    ro_puf_controller #(
        .NUM_PAIRS(NP), .SEL_W(SW), .WINDOW(WIN), .SETTLE(ST), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [CW-1:0] ca [NP];
    logic [CW-1:0] cb [NP];
    assign bus.cnt_a = ca[bus.ro_sel];
    assign bus.cnt_b = cb[bus.ro_sel];

    typedef struct packed {
        logic [NP-1:0][CW-1:0] a;
        logic [NP-1:0][CW-1:0] b;
        logic [NP-1:0]         er;
        logic [SW:0]           et;
    } vec_t;

    typedef struct packed {
        logic [NP-1:0] er;
        logic [SW:0]   et;
    } exp_t;

    vec_t tv [4];
    exp_t exp_q [$];
    logic [NP-1:0] prev_er;
    logic [SW:0]   prev_et;
    int checks = 0;
    int errs   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic [CW-1:0] a0, a1, a2, a3, b0, b1, b2, b3,
                                input logic [NP-1:0] er, input logic [SW:0] et);
        vec_t v;
        v.a  = {a3, a2, a1, a0};
        v.b  = {b3, b2, b1, b0};
        v.er = er;
        v.et = et;
        return v;
    endfunction

    task automatic load_counts(input int vi);
        for (int i = 0; i < NP; i++) begin
            ca[i] = tv[vi].a[i];
            cb[i] = tv[vi].b[i];
        end
    endtask

    task automatic run(input int vi, input bit mid_req, input int hold, input bit req_with_ack);
        logic clr_t [64];
        logic en_t  [64];
        logic [SW-1:0] sel_t [64];
        int n;
        bit seen;
        int bad;
        exp_t e;
        load_counts(vi);
        @(negedge clk);
        bus.req = 1'b1;
        exp_q.push_back('{er: tv[vi].er, et: tv[vi].et});
        @(negedge clk);
        bus.req = 1'b0;
        chk("busy_after_req", 64'(bus.busy), 64'(1));
        n = 0;
        seen = 1'b0;
        while (n < 200) begin
            if (bus.resp_valid) begin
                seen = 1'b1;
                break;
            end
            if (n < 64) begin
                clr_t[n] = bus.ro_clr;
                en_t[n]  = bus.ro_en;
                sel_t[n] = bus.ro_sel;
            end
            if (n == 30) chk("resp_hold_midrun", 64'({bus.resp, bus.ties}), 64'({prev_er, prev_et}));
            if (mid_req) bus.req = (n == 20);
            @(negedge clk);
            n++;
        end
        bus.req = 1'b0;
        if (!seen) begin
            chk("resp_valid_timeout", 64'(0), 64'(1));
            return;
        end
        chk("latency", 64'(n), 64'(LAT));
        bad = 0;
        for (int k = 0; k < NP * PT; k++) begin
            if (clr_t[k] !== ((k % PT) == 0)) bad++;
            if (en_t[k] !== (((k % PT) >= 1) && ((k % PT) <= WIN))) bad++;
            if (sel_t[k] !== SW'(k / PT)) bad++;
            if (clr_t[k] && en_t[k]) bad++;
        end
        chk("waveform", 64'(bad), 64'(0));
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.resp_valid || !bus.busy || bus.resp !== tv[vi].er) bad++;
        end
        if (hold > 0) chk("handshake_hold", 64'(bad), 64'(0));
        e = exp_q.pop_front();
        chk("resp", 64'(bus.resp), 64'(e.er));
        chk("ties", 64'(bus.ties), 64'(e.et));
        prev_er = e.er;
        prev_et = e.et;
        bus.resp_ack = 1'b1;
        bus.req = req_with_ack;
        @(negedge clk);
        bus.resp_ack = 1'b0;
        bus.req = 1'b0;
        chk("valid_after_ack", 64'(bus.resp_valid), 64'(0));
        chk("busy_after_ack", 64'(bus.busy), 64'(0));
        if (req_with_ack) begin
            bad = 0;
            repeat (3) begin
                @(negedge clk);
                if (bus.busy || bus.ro_clr) bad++;
            end
            chk("req_with_ack_not_queued", 64'(bad), 64'(0));
        end
    endtask

    task automatic reset_mid_run();
        int n;
        load_counts(0);
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        n = 0;
        while (n < 2 * PT + 3) begin
            @(negedge clk);
            n++;
        end
        chk("pair2_measuring", 64'({bus.ro_sel, bus.ro_en}), 64'({SW'(2), 1'b1}));
        rst = 1'b1;
        #1;
        chk("rst_ro_en", 64'(bus.ro_en), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_resp", 64'({bus.resp, bus.ties}), 64'(0));
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        prev_er = '0;
        prev_et = '0;
    endtask

    initial begin
        tv[0] = mk(16'd10, 16'd3, 16'd9, 16'd20, 16'd5, 16'd7, 16'd9, 16'd1, 4'b1001, 3'd1);
        tv[1] = mk(16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 4'b0000, 3'd4);
        tv[2] = mk(16'hFFFF, 16'h0000, 16'd1, 16'd5, 16'h0000, 16'hFFFF, 16'd0, 16'd5, 4'b0101, 3'd1);
        tv[3] = mk(16'd100, 16'h8000, 16'd2, 16'd0, 16'd200, 16'h7FFF, 16'd1, 16'd0, 4'b0110, 3'd1);
        prev_er = '0;
        prev_et = '0;
        rst = 1'b1;
        bus.req = 1'b0;
        bus.resp_ack = 1'b0;
        for (int i = 0; i < NP; i++) begin
            ca[i] = '0;
            cb[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({bus.busy, bus.ro_en, bus.ro_clr, bus.resp_valid}), 64'(0));
        chk("reset_data", 64'({bus.resp, bus.ties, bus.ro_sel}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        bus.resp_ack = 1'b1;
        @(negedge clk);
        bus.resp_ack = 1'b0;
        chk("ack_while_idle", 64'({bus.busy, bus.resp_valid}), 64'(0));

        run(0, 1'b1, 20, 1'b0);
        run(2, 1'b0, 0, 1'b0);
        reset_mid_run();
        run(0, 1'b0, 0, 1'b0);
        run(1, 1'b0, 3, 1'b1);
        run(3, 1'b0, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
